// File: rtl/sm_addsub_if.sv
// sm_addsub_if: operand/result handshake bundle for sm_addsub_pipe.
//   in_valid/in_ready/op/a/b  : operand beat, source -> pipe
//   out_valid/out_ready/c/ovf : result beat, pipe -> consumer
// Widths follow the sign-magnitude convention: the operand is MAG_W+1 bits
// and the result is MAG_W+2 bits, with the sign in the MSB of each.
interface sm_addsub_if #(
  parameter int MAG_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic             op;
  logic [MAG_W:0]   a;
  logic [MAG_W:0]   b;
  logic             out_valid;
  logic             out_ready;
  logic [MAG_W+1:0] c;
  logic             ovf;

  // master: drives operands and consumes results (source + sink side)
  modport master (
    output in_valid, op, a, b, out_ready,
    input  in_ready, out_valid, c, ovf
  );

  // slave: the pipeline itself
  modport slave (
    input  in_valid, op, a, b, out_ready,
    output in_ready, out_valid, c, ovf
  );
endinterface

// File: rtl/sm_addsub_pipe.sv
// sm_addsub_pipe: 3-stage sign-magnitude fixed-point adder/subtractor with
// valid/ready flow control, an overflow flag and a saturating overflow counter.
//   clk, rst  : clock, synchronous active-high reset
//   bus       : sm_addsub_if.slave (operand in, result out, handshakes)
//   ovf_count : number of consumed results with ovf=1, saturating
// Stages: S1 register split sign/magnitude (op folded into b's sign),
//         S2 add or subtract magnitudes, S3 normalise -0 and register output.
// One global stall: every stage moves only when the output slot is free or
// being drained this cycle.
module sm_addsub_pipe #(
  parameter int MAG_W  = 4,
  parameter int FRAC_W = 2,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  sm_addsub_if.slave       bus,
  output logic [CNT_W-1:0] ovf_count
);
  localparam int STAGES = 3;
  // Magnitude = integer bits followed by fraction bits; the arithmetic is
  // blind to the split, it only matters to whoever interprets c.
  localparam int INT_W  = MAG_W - FRAC_W;

  typedef logic [INT_W+FRAC_W-1:0] mag_t;

  typedef struct packed {
    logic sa;
    logic sb;
    mag_t ma;
    mag_t mb;
  } s1_t;

  typedef struct packed {
    logic           sign;
    logic [MAG_W:0] mag;
  } s2_t;

  logic [STAGES:1]  vld_pipe;
  s1_t              s1_q;
  s2_t              s2_d, s2_q;
  logic [MAG_W+1:0] c_q;
  logic             ovf_q;
  logic             advance;

  assign advance       = !vld_pipe[STAGES] || bus.out_ready;
  assign bus.in_ready  = advance;
  assign bus.out_valid = vld_pipe[STAGES];
  assign bus.c         = c_q;
  assign bus.ovf       = ovf_q;

  // Larger magnitude minus smaller, so the difference never wraps; the
  // result takes the sign of the larger operand (a wins ties).
  always_comb begin
    s2_d.sign = s1_q.sa;
    s2_d.mag  = '0;
    if (s1_q.sa == s1_q.sb) begin
      s2_d.mag = {1'b0, s1_q.ma} + {1'b0, s1_q.mb};
    end else if (s1_q.ma >= s1_q.mb) begin
      s2_d.mag = {1'b0, s1_q.ma - s1_q.mb};
    end else begin
      s2_d.mag  = {1'b0, s1_q.mb - s1_q.ma};
      s2_d.sign = s1_q.sb;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe  <= '0;
      c_q       <= '0;
      ovf_q     <= 1'b0;
      ovf_count <= '0;
    end else begin
      if (advance) begin
        vld_pipe  <= {vld_pipe[STAGES-1:1], bus.in_valid};
        s1_q.sa   <= bus.a[MAG_W];
        s1_q.sb   <= bus.b[MAG_W] ^ bus.op;
        s1_q.ma   <= bus.a[MAG_W-1:0];
        s1_q.mb   <= bus.b[MAG_W-1:0];
        s2_q      <= s2_d;
        // zero magnitude always leaves as +0
        c_q       <= {s2_q.sign & (s2_q.mag != '0), s2_q.mag};
        ovf_q     <= s2_q.mag[MAG_W];
      end
      if (vld_pipe[STAGES] && bus.out_ready && ovf_q && (ovf_count != '1))
        ovf_count <= ovf_count + CNT_W'(1);
    end
  end
endmodule

// File: tb/tb_sm_addsub_pipe.sv
// Directed self-checking bench for sm_addsub_pipe (MAG_W=4). A second
// instance with CNT_W=2 exercises counter saturation.
module tb_sm_addsub_pipe;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] cnt8;
  logic [1:0] cnt2;
  int         checks = 0;
  int         errors = 0;
  int         exp_cnt = 0;

  sm_addsub_if #(.MAG_W(4)) bus ();
  sm_addsub_if #(.MAG_W(4)) bus2 ();

  sm_addsub_pipe #(.MAG_W(4), .FRAC_W(2), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .bus(bus.slave), .ovf_count(cnt8)
  );
  sm_addsub_pipe #(.MAG_W(4), .FRAC_W(2), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2.slave), .ovf_count(cnt2)
  );

  always #5 clk = ~clk;

  // Stream vectors: {ovf, c} expected, computed by hand.
  logic [4:0] va   [5] = '{5'b00001, 5'b00111, 5'b10010, 5'b01001, 5'b11000};
  logic [4:0] vb   [5] = '{5'b00010, 5'b00001, 5'b00110, 5'b11001, 5'b01000};
  logic       vop  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [6:0] vexp [5] = '{7'b0000011, 7'b0000110, 7'b0000100, 7'b0000000, 7'b1110000};

  // One beat through an idle pipe with out_ready high; returns the result
  // and the number of rising edges from acceptance to out_valid.
  task automatic xact(input logic op, input logic [4:0] a, input logic [4:0] b,
                      output logic [5:0] c, output logic ovf, output int lat);
    int w = 0;
    bus.op = op; bus.a = a; bus.b = b; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    #1;
    while (!bus.in_ready && w < 20) begin @(posedge clk); #1; w++; end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    c = bus.c; ovf = bus.ovf;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (cnt8 !== 8'd0) begin errors++; $display("FAIL reset_ovf_count got=%0d exp=0", cnt8); end
    checks++; if (cnt2 !== 2'd0) begin errors++; $display("FAIL reset_ovf_count2 got=%0d exp=0", cnt2); end
    checks++; if ({bus.ovf, bus.c} !== 7'd0) begin errors++; $display("FAIL reset_c_ovf got=%b exp=0000000", {bus.ovf, bus.c}); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    rst = 1'b0;
    exp_cnt = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_opp_sign();
    logic [5:0] c; logic o; int lat;
    xact(1'b0, 5'b00101, 5'b10011, c, o, lat);
    checks++; if (c !== 6'b000010) begin errors++; $display("FAIL opp_pos_c got=%b exp=000010", c); end
    checks++; if (o !== 1'b0) begin errors++; $display("FAIL opp_pos_ovf got=%b exp=0", o); end
    checks++; if (lat !== 3) begin errors++; $display("FAIL latency got=%0d exp=3", lat); end
    xact(1'b0, 5'b00011, 5'b10101, c, o, lat);
    checks++; if (c !== 6'b100010) begin errors++; $display("FAIL opp_neg_c got=%b exp=100010", c); end
  endtask

  task automatic test_overflow();
    logic [5:0] c; logic o; int lat;
    xact(1'b0, 5'b01111, 5'b01111, c, o, lat);
    exp_cnt++;
    checks++; if ({o, c} !== 7'b1011110) begin errors++; $display("FAIL ovf_pos got=%b exp=1011110", {o, c}); end
    checks++; if (cnt8 !== 8'(exp_cnt)) begin errors++; $display("FAIL ovf_count_1 got=%0d exp=%0d", cnt8, exp_cnt); end
    xact(1'b0, 5'b11111, 5'b11111, c, o, lat);
    exp_cnt++;
    checks++; if ({o, c} !== 7'b1111110) begin errors++; $display("FAIL ovf_neg got=%b exp=1111110", {o, c}); end
    checks++; if (cnt8 !== 8'(exp_cnt)) begin errors++; $display("FAIL ovf_count_2 got=%0d exp=%0d", cnt8, exp_cnt); end
  endtask

  task automatic test_zero();
    logic [5:0] c; logic o; int lat;
    xact(1'b1, 5'b10100, 5'b10100, c, o, lat);
    checks++; if ({o, c} !== 7'b0000000) begin errors++; $display("FAIL zero_sub got=%b exp=0000000", {o, c}); end
    xact(1'b0, 5'b10000, 5'b00000, c, o, lat);
    checks++; if ({o, c} !== 7'b0000000) begin errors++; $display("FAIL neg_zero_in got=%b exp=0000000", {o, c}); end
    xact(1'b1, 5'b00000, 5'b00111, c, o, lat);
    checks++; if ({o, c} !== 7'b0100111) begin errors++; $display("FAIL zero_minus_7 got=%b exp=0100111", {o, c}); end
  endtask

  task automatic test_back_to_back();
    int src = 0, got = 0, first = -1, last = -1;
    logic [6:0] res [5];
    logic hs_in, hs_out;
    for (int cyc = 0; cyc < 30 && got < 5; cyc++) begin
      bus.out_ready = 1'b1;
      bus.in_valid  = (src < 5);
      if (src < 5) begin bus.a = va[src]; bus.b = vb[src]; bus.op = vop[src]; end
      #1;
      hs_in  = bus.in_valid && bus.in_ready;
      hs_out = bus.out_valid && bus.out_ready;
      if (hs_out) begin
        if (got == 0) first = cyc;
        res[got] = {bus.ovf, bus.c};
        last = cyc;
        got++;
      end
      if (hs_in) src++;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    exp_cnt++;
    checks++; if (got !== 5) begin errors++; $display("FAIL b2b_count got=%0d exp=5", got); end
    checks++; if (first !== 3) begin errors++; $display("FAIL b2b_first_cycle got=%0d exp=3", first); end
    checks++; if (last - first !== 4) begin errors++; $display("FAIL b2b_span got=%0d exp=4", last - first); end
    for (int i = 0; i < got; i++) begin
      checks++; if (res[i] !== vexp[i]) begin errors++; $display("FAIL b2b_res%0d got=%b exp=%b", i, res[i], vexp[i]); end
    end
    checks++; if (cnt8 !== 8'(exp_cnt)) begin errors++; $display("FAIL b2b_ovf_count got=%0d exp=%0d", cnt8, exp_cnt); end
  endtask

  task automatic test_backpressure();
    int src = 0, got = 0;
    logic [6:0] res [5];
    logic [6:0] held = '0;
    logic stalled_prev = 1'b0;
    logic hs_in, hs_out;
    for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
      bus.out_ready = !(cyc >= 4 && cyc < 8);
      bus.in_valid  = (src < 5);
      if (src < 5) begin bus.a = va[src]; bus.b = vb[src]; bus.op = vop[src]; end
      #1;
      hs_in  = bus.in_valid && bus.in_ready;
      hs_out = bus.out_valid && bus.out_ready;
      if (bus.out_valid && !bus.out_ready) begin
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", cyc, bus.in_ready); end
        if (stalled_prev) begin
          checks++; if ({bus.ovf, bus.c} !== held) begin errors++; $display("FAIL bp_hold cyc=%0d got=%b exp=%b", cyc, {bus.ovf, bus.c}, held); end
        end
        held = {bus.ovf, bus.c};
        stalled_prev = 1'b1;
      end else begin
        stalled_prev = 1'b0;
      end
      if (hs_out) begin res[got] = {bus.ovf, bus.c}; got++; end
      if (hs_in) src++;
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    exp_cnt++;
    checks++; if (src !== 5) begin errors++; $display("FAIL bp_accepted got=%0d exp=5", src); end
    checks++; if (got !== 5) begin errors++; $display("FAIL bp_count got=%0d exp=5", got); end
    for (int i = 0; i < got; i++) begin
      checks++; if (res[i] !== vexp[i]) begin errors++; $display("FAIL bp_res%0d got=%b exp=%b", i, res[i], vexp[i]); end
    end
    checks++; if (cnt8 !== 8'(exp_cnt)) begin errors++; $display("FAIL bp_ovf_count got=%0d exp=%0d", cnt8, exp_cnt); end
  endtask

  task automatic test_reset_mid();
    logic seen = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.a = va[4]; bus.b = vb[4]; bus.op = vop[4];
    @(posedge clk); #1;
    bus.a = 5'b01111; bus.b = 5'b01111; bus.op = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_cnt = 0;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_out_valid got=%b exp=0", bus.out_valid); end
    checks++; if (cnt8 !== 8'd0) begin errors++; $display("FAIL rstmid_ovf_count got=%0d exp=0", cnt8); end
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rstmid_stale got=%b exp=0", seen); end
    checks++; if (cnt8 !== 8'd0) begin errors++; $display("FAIL rstmid_count_after got=%0d exp=0", cnt8); end
  endtask

  task automatic test_saturation();
    int n = 0;
    bus2.a = 5'b01111; bus2.b = 5'b01111; bus2.op = 1'b0; bus2.out_ready = 1'b1;
    for (int cyc = 0; cyc < 14; cyc++) begin
      bus2.in_valid = (cyc < 5);
      #1;
      if (bus2.out_valid && bus2.out_ready && bus2.ovf) n++;
      @(posedge clk); #1;
    end
    bus2.in_valid = 1'b0;
    checks++; if (n !== 5) begin errors++; $display("FAIL sat_results got=%0d exp=5", n); end
    checks++; if (cnt2 !== 2'd3) begin errors++; $display("FAIL sat_count got=%0d exp=3", cnt2); end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.op = 1'b0; bus.a = '0; bus.b = '0; bus.out_ready = 1'b1;
    bus2.in_valid = 1'b0; bus2.op = 1'b0; bus2.a = '0; bus2.b = '0; bus2.out_ready = 1'b1;
    test_reset();
    test_opp_sign();
    test_overflow();
    test_zero();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sm_addsub_pipe.md
Name: sm_addsub_pipe

Overview:
- Parametrised, fully pipelined sign-magnitude fixed-point adder/subtractor; next generation of the team's 5-bit Q-format sign-magnitude adder.
- Adds per-transaction add/sub mode, correct opposite-sign handling, negative-zero normalisation, valid/ready flow control with backpressure, and an overflow flag plus a saturating overflow counter.
- Sits between an operand source and a result consumer in the datapath.

Parameters:
MAG_W, 4, magnitude bits per operand (operand width = MAG_W+1, sign is MSB)
FRAC_W, 2, fraction bits within the magnitude; Q-format bookkeeping only, does not affect arithmetic
CNT_W, 8, width of the overflow event counter

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, synchronous, active-high
in_valid  in  1  operand beat valid
in_ready  out  1  block can accept a beat this cycle
op  in  1  0 = a+b, 1 = a-b
a  in  MAG_W+1  operand A, sign-magnitude, [MAG_W] = sign
b  in  MAG_W+1  operand B, sign-magnitude
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
c  out  MAG_W+2  result, sign-magnitude: [MAG_W+1] = sign, [MAG_W:0] = magnitude
ovf  out  1  result magnitude exceeds MAG_W bits (c[MAG_W] set); qualified by out_valid
ovf_count  out  CNT_W  number of accepted results with ovf=1, saturates at all-ones

Behaviour:
- Reset (synchronous, active-high, sampled on clk rising edge): all stage valids, c, ovf and ovf_count clear to 0. A beat in flight when reset is sampled is discarded; no partial output follows.
- Input handshake: beat accepted when in_valid && in_ready. Output handshake: result consumed when out_valid && out_ready.
- Global stall: advance = !out_valid || out_ready. in_ready = advance, combinational. When advance=0, every stage register holds. When advance=1, all stages shift and empty stages propagate as bubbles. Bubbles are not collapsed.
- Latency is exactly 3 cycles from acceptance to out_valid when out_ready is held high. Throughput is 1 beat/cycle.
- Stage 1:
  - Register magnitudes ma = a[MAG_W-1:0] and mb = b[MAG_W-1:0].
  - Sign sa = a[MAG_W].
  - Effective sign sb = b[MAG_W] XOR op.
  - A zero magnitude keeps its sign bit here; it is neutralised in stage 3.
- Stage 2, computed at MAG_W+1 bits:
  - If sa == sb: mag = ma + mb, sign = sa.
  - Else if ma >= mb: mag = ma - mb, sign = sa.
  - Else: mag = mb - ma, sign = sb.
  - Subtraction never wraps.
- Stage 3:
  - If mag == 0, force sign = 0, so no -0 is ever output.
  - c = {sign, mag}.
  - ovf = mag[MAG_W], which can only be set on same-sign addition.
- Output registers hold value while out_valid && !out_ready.
- c and ovf are don't-care when out_valid = 0, but must not change while stalled.
- ovf_count:
  - Increments by 1 on each cycle with out_valid && out_ready && ovf.
  - Saturates at 2^CNT_W-1.
  - Cleared only by rst.
- Operands are not checked for -0 on input. -0 behaves as +0, with the result normalised per the stage 3 rule.
- Simultaneous events: with out_valid=1 and out_ready=1, a new input is accepted in the same cycle the output drains.

Test Plan (MAG_W=4):
- Opposite-sign add:
  - a=5'b00101 (+5), b=5'b10011 (-3), op=0 -> c=6'b000010 (+2), ovf=0, out_valid exactly 3 cycles after acceptance.
  - a=+3, b=-5, op=0 -> c=6'b100010 (-2).
- Overflow: a=+15, b=+15, op=0 -> c=6'b011110, ovf=1, ovf_count 0->1 on consume. Same with a=-15, b=-15 -> c=6'b111110.
- Zero/sign normalisation:
  - a=-4, b=-4, op=1 -> c=6'b000000.
  - a=5'b10000 (-0), b=5'b00000, op=0 -> c=6'b000000.
  - a=+0, b=+7, op=1 -> c=6'b100111 (-7).
- Backpressure:
  - Stream 5 back-to-back beats, then hold out_ready=0 for 4 cycles -> in_ready=0 during the stall, c stable, no beat lost or duplicated, results in order.
  - Streaming at out_ready=1 -> one result per cycle.
- Reset mid-operation: accept 2 beats, assert rst one cycle -> next cycle out_valid=0, ovf_count=0, no stale results emerge afterward.
- Counter saturation: with CNT_W=2, drain 5 overflowing results -> ovf_count stops at 3.
